// File: rtl/uart_baud_pkg.sv
// Shared defaults for the UART baud generator and its prescaler.
// The FRAC_DIV_EN build macro enables the fractional divisor; FRAC_W_DEF sizes it.
package uart_baud_pkg;

    localparam int DIV_WIDTH_DEF   = 16;
    localparam int OVERSAMPLE_DEF  = 16;
    localparam int DEFAULT_DIV_DEF = 1;
    localparam int FRAC_W_DEF      = 4;

    function automatic int os_cnt_w(input int oversample);
        return $clog2(oversample);
    endfunction

    localparam int OS_CNT_W_DEF = os_cnt_w(OVERSAMPLE_DEF);

endpackage

// File: rtl/uart_prescaler.sv
// Divides baurd_clk by the active divisor into a one-cycle os_tick.
// With FRAC_DIV_EN defined, a fractional accumulator stretches some periods by one cycle.
module uart_prescaler
    import uart_baud_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
`ifdef FRAC_DIV_EN
    ,
    parameter int FRAC_W = FRAC_W_DEF
`endif
) (
    input  logic                 baurd_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div_active,
`ifdef FRAC_DIV_EN
    input  logic [FRAC_W-1:0]    frac_active,
`endif
    output logic                 tick_gen,
    output logic                 os_tick
);

    logic [DIV_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic                 os_tick_q, os_tick_d;
    logic [DIV_WIDTH:0]   term;

`ifdef FRAC_DIV_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [FRAC_W:0]   acc_sum;

    // A carry out of the accumulator lengthens the following period by one cycle.
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_active};
    assign term    = {1'b0, div_active} - {{DIV_WIDTH{1'b0}}, 1'b1}
                   + {{DIV_WIDTH{1'b0}}, ext_q};
`else
    assign term    = {1'b0, div_active} - {{DIV_WIDTH{1'b0}}, 1'b1};
`endif

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        os_tick_d = 1'b0;
`ifdef FRAC_DIV_EN
        acc_d     = acc_q;
        ext_d     = ext_q;
`endif
        if (restart) begin
            pre_cnt_d = '0;
`ifdef FRAC_DIV_EN
            acc_d     = '0;
            ext_d     = 1'b0;
`endif
        end else if (enable) begin
            if ({1'b0, pre_cnt_q} == term) begin
                pre_cnt_d = '0;
                os_tick_d = 1'b1;
`ifdef FRAC_DIV_EN
                acc_d     = acc_sum[FRAC_W-1:0];
                ext_d     = acc_sum[FRAC_W];
`endif
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge baurd_clk) begin
        if (!reset) begin
            pre_cnt_q <= '0;
            os_tick_q <= 1'b0;
`ifdef FRAC_DIV_EN
            acc_q     <= '0;
            ext_q     <= 1'b0;
`endif
        end else begin
            pre_cnt_q <= pre_cnt_d;
            os_tick_q <= os_tick_d;
`ifdef FRAC_DIV_EN
            acc_q     <= acc_d;
            ext_q     <= ext_d;
`endif
        end
    end

    assign tick_gen = os_tick_d;
    assign os_tick  = os_tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable UART baud generator: oversample, mid-bit and baud strobes plus clock_out.
// Define FRAC_DIV_EN to add the div_frac port and fractional divisor support.
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
`ifdef FRAC_DIV_EN
    ,
    parameter int FRAC_W      = FRAC_W_DEF
`endif
) (
    input  logic                 baurd_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 restart,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
`ifdef FRAC_DIV_EN
    input  logic [FRAC_W-1:0]    div_frac,
`endif
    output logic                 os_tick,
    output logic                 mid_tick,
    output logic                 baud_tick,
    output logic                 clock_out,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 div_pending,
    output logic                 div_err
);

    localparam int                   OS_CNT_W = os_cnt_w(OVERSAMPLE);
    localparam logic [OS_CNT_W-1:0]  OS_LAST  = OS_CNT_W'(OVERSAMPLE - 1);
    localparam logic [OS_CNT_W-1:0]  OS_MID   = OS_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);

    logic [OS_CNT_W-1:0]  os_cnt_q, os_cnt_d;
    logic                 mid_tick_q, mid_tick_d;
    logic                 baud_tick_q, baud_tick_d;
    logic                 clock_out_q, clock_out_d;
    logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
    logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
    logic                 div_pending_q, div_pending_d;
    logic                 div_err_q, div_err_d;
    logic                 tick_gen, load_ok, apply;
`ifdef FRAC_DIV_EN
    logic [FRAC_W-1:0]    frac_active_q, frac_active_d;
    logic [FRAC_W-1:0]    frac_shadow_q, frac_shadow_d;
`endif

    uart_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
`ifdef FRAC_DIV_EN
        ,
        .FRAC_W    (FRAC_W)
`endif
    ) u_pre (
        .baurd_clk   (baurd_clk),
        .reset       (reset),
        .enable      (enable),
        .restart     (restart),
        .div_active  (div_active_q),
`ifdef FRAC_DIV_EN
        .frac_active (frac_active_q),
`endif
        .tick_gen    (tick_gen),
        .os_tick     (os_tick)
    );

    assign load_ok = div_load && (div_value != '0);

    always_comb begin
        os_cnt_d    = os_cnt_q;
        mid_tick_d  = tick_gen && (os_cnt_q == OS_MID);
        baud_tick_d = tick_gen && (os_cnt_q == OS_LAST);
        clock_out_d = clock_out_q ^ baud_tick_d;
        if (restart)
            os_cnt_d = '0;
        else if (tick_gen)
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
    end

    // Divisor changes only land on a bit boundary or a restart, so no bit is resized.
    assign apply = baud_tick_d || restart;

    always_comb begin
        shadow_d      = shadow_q;
        div_active_d  = div_active_q;
        div_pending_d = div_pending_q;
        div_err_d     = div_err_q | (div_load && (div_value == '0));
`ifdef FRAC_DIV_EN
        frac_shadow_d = frac_shadow_q;
        frac_active_d = frac_active_q;
`endif
        if (load_ok) begin
            shadow_d = div_value;
`ifdef FRAC_DIV_EN
            frac_shadow_d = div_frac;
`endif
        end
        if (apply) begin
            div_pending_d = 1'b0;
            if (load_ok) begin
                div_active_d = div_value;
`ifdef FRAC_DIV_EN
                frac_active_d = div_frac;
`endif
            end else if (div_pending_q) begin
                div_active_d = shadow_q;
`ifdef FRAC_DIV_EN
                frac_active_d = frac_shadow_q;
`endif
            end
        end else if (load_ok) begin
            div_pending_d = 1'b1;
        end
    end

    always_ff @(posedge baurd_clk) begin
        if (!reset) begin
            os_cnt_q      <= '0;
            mid_tick_q    <= 1'b0;
            baud_tick_q   <= 1'b0;
            clock_out_q   <= 1'b0;
            div_active_q  <= DIV_RST;
            shadow_q      <= DIV_RST;
            div_pending_q <= 1'b0;
            div_err_q     <= 1'b0;
`ifdef FRAC_DIV_EN
            frac_active_q <= '0;
            frac_shadow_q <= '0;
`endif
        end else begin
            os_cnt_q      <= os_cnt_d;
            mid_tick_q    <= mid_tick_d;
            baud_tick_q   <= baud_tick_d;
            clock_out_q   <= clock_out_d;
            div_active_q  <= div_active_d;
            shadow_q      <= shadow_d;
            div_pending_q <= div_pending_d;
            div_err_q     <= div_err_d;
`ifdef FRAC_DIV_EN
            frac_active_q <= frac_active_d;
            frac_shadow_q <= frac_shadow_d;
`endif
        end
    end

    assign mid_tick    = mid_tick_q;
    assign baud_tick   = baud_tick_q;
    assign clock_out   = clock_out_q;
    assign div_active  = div_active_q;
    assign div_pending = div_pending_q;
    assign div_err     = div_err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen with default parameters (DIV_WIDTH=16, OVERSAMPLE=16, DEFAULT_DIV=1).
// The fractional divisor scenario is built only when FRAC_DIV_EN is defined.
module tb_uart_baud_gen;

    logic        baurd_clk = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic        restart   = 1'b0;
    logic        div_load  = 1'b0;
    logic [15:0] div_value = '0;
`ifdef FRAC_DIV_EN
    logic [3:0]  div_frac  = '0;
`endif
    logic        os_tick, mid_tick, baud_tick, clock_out;
    logic [15:0] div_active;
    logic        div_pending, div_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_clk = 1'b0;

    uart_baud_gen dut (
        .baurd_clk   (baurd_clk),
        .reset       (reset),
        .enable      (enable),
        .restart     (restart),
        .div_load    (div_load),
        .div_value   (div_value),
`ifdef FRAC_DIV_EN
        .div_frac    (div_frac),
`endif
        .os_tick     (os_tick),
        .mid_tick    (mid_tick),
        .baud_tick   (baud_tick),
        .clock_out   (clock_out),
        .div_active  (div_active),
        .div_pending (div_pending),
        .div_err     (div_err)
    );

    always #5 baurd_clk = ~baurd_clk;

    // Advance one edge and settle; inputs set afterwards are sampled on the next edge.
    task automatic cyc();
        @(posedge baurd_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1;
        repeat (3) cyc();
        n_chk++;
        if ({os_tick, mid_tick, baud_tick, clock_out} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ticks got %b want 0000", {os_tick, mid_tick, baud_tick, clock_out});
        end
        n_chk++;
        if (div_active !== 16'd1) begin
            n_fail++; $display("FAIL reset_div_active got %0d want 1", div_active);
        end
        n_chk++;
        if (div_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_div_pending got %b want 0", div_pending);
        end
        n_chk++;
        if (div_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_div_err got %b want 0", div_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_legacy();
        logic [3:0] ev;
        for (int k = 1; k <= 64; k++) begin
            cyc();
            if (k % 16 == 0) exp_clk = ~exp_clk;
            ev = {1'b1, (k % 16 == 8), (k % 16 == 0), exp_clk};
            n_chk++;
            if ({os_tick, mid_tick, baud_tick, clock_out} !== ev) begin
                n_fail++; $display("FAIL legacy k=%0d got %b want %b", k, {os_tick, mid_tick, baud_tick, clock_out}, ev);
            end
        end
    endtask

    task automatic test_div_load();
        logic [3:0] ev;
        bit found = 0;
        div_load = 1'b1; div_value = 16'd5;
        cyc();
        div_load = 1'b0;
        n_chk++;
        if (div_pending !== 1'b1 || div_active !== 16'd1) begin
            n_fail++; $display("FAIL load_pending got p=%b a=%0d want p=1 a=1", div_pending, div_active);
        end
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (baud_tick === 1'b1) begin found = 1; break; end
            n_chk++;
            if (div_pending !== 1'b1) begin
                n_fail++; $display("FAIL load_hold i=%0d pending=%b want 1", i, div_pending);
            end
        end
        exp_clk = ~exp_clk;
        n_chk++;
        if (!found) begin
            n_fail++; $display("FAIL load_baud_timeout got none want baud_tick within 40");
        end
        n_chk++;
        if (div_pending !== 1'b0 || div_active !== 16'd5 || clock_out !== exp_clk) begin
            n_fail++; $display("FAIL load_apply got p=%b a=%0d c=%b want p=0 a=5 c=%b", div_pending, div_active, clock_out, exp_clk);
        end
        for (int j = 1; j <= 80; j++) begin
            cyc();
            if (j == 80) exp_clk = ~exp_clk;
            ev = {(j % 5 == 0), (j == 40), (j == 80), exp_clk};
            n_chk++;
            if ({os_tick, mid_tick, baud_tick, clock_out} !== ev) begin
                n_fail++; $display("FAIL div5 j=%0d got %b want %b", j, {os_tick, mid_tick, baud_tick, clock_out}, ev);
            end
        end
    endtask

    task automatic test_div_err();
        bit found = 0;
        div_load = 1'b1; div_value = 16'd0;
        cyc();
        div_load = 1'b0;
        n_chk++;
        if (div_err !== 1'b1 || div_active !== 16'd5 || div_pending !== 1'b0) begin
            n_fail++; $display("FAIL err_zero got e=%b a=%0d p=%b want e=1 a=5 p=0", div_err, div_active, div_pending);
        end
        div_load = 1'b1; div_value = 16'd3;
        cyc();
        div_load = 1'b0;
        n_chk++;
        if (div_err !== 1'b1 || div_pending !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got e=%b p=%b want e=1 p=1", div_err, div_pending);
        end
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (baud_tick === 1'b1) begin found = 1; break; end
        end
        exp_clk = ~exp_clk;
        n_chk++;
        if (!found) begin
            n_fail++; $display("FAIL err_baud_timeout got none want baud_tick within 100");
        end
        n_chk++;
        if (div_active !== 16'd3 || div_err !== 1'b1 || div_pending !== 1'b0) begin
            n_fail++; $display("FAIL err_apply got a=%0d e=%b p=%b want a=3 e=1 p=0", div_active, div_err, div_pending);
        end
    endtask

    task automatic test_restart();
        logic [3:0] ev;
        for (int i = 1; i <= 29; i++) begin
            cyc();
            ev = {(i % 3 == 0), (i == 24), 1'b0, exp_clk};
            n_chk++;
            if ({os_tick, mid_tick, baud_tick, clock_out} !== ev) begin
                n_fail++; $display("FAIL pre_restart i=%0d got %b want %b", i, {os_tick, mid_tick, baud_tick, clock_out}, ev);
            end
        end
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        n_chk++;
        if ({os_tick, mid_tick, baud_tick, clock_out} !== {3'b000, exp_clk}) begin
            n_fail++; $display("FAIL restart_quiet got %b want %b", {os_tick, mid_tick, baud_tick, clock_out}, {3'b000, exp_clk});
        end
        for (int j = 1; j <= 48; j++) begin
            cyc();
            if (j == 48) exp_clk = ~exp_clk;
            ev = {(j % 3 == 0), (j == 24), (j == 48), exp_clk};
            n_chk++;
            if ({os_tick, mid_tick, baud_tick, clock_out} !== ev) begin
                n_fail++; $display("FAIL post_restart j=%0d got %b want %b", j, {os_tick, mid_tick, baud_tick, clock_out}, ev);
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] ev;
        for (int j = 1; j <= 48; j++) begin
            if (j == 5) begin
                enable = 1'b0;
                for (int p = 0; p < 7; p++) begin
                    cyc();
                    n_chk++;
                    if ({os_tick, mid_tick, baud_tick, clock_out} !== {3'b000, exp_clk}) begin
                        n_fail++; $display("FAIL enable_low p=%0d got %b want %b", p, {os_tick, mid_tick, baud_tick, clock_out}, {3'b000, exp_clk});
                    end
                end
                enable = 1'b1;
            end
            cyc();
            if (j == 48) exp_clk = ~exp_clk;
            ev = {(j % 3 == 0), (j == 24), (j == 48), exp_clk};
            n_chk++;
            if ({os_tick, mid_tick, baud_tick, clock_out} !== ev) begin
                n_fail++; $display("FAIL enable_resume j=%0d got %b want %b", j, {os_tick, mid_tick, baud_tick, clock_out}, ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ev;
        restart = 1'b1; div_load = 1'b1; div_value = 16'd4;
        cyc();
        restart = 1'b0; div_load = 1'b0;
        n_chk++;
        if (div_active !== 16'd4 || div_pending !== 1'b0) begin
            n_fail++; $display("FAIL coincident_load got a=%0d p=%b want a=4 p=0", div_active, div_pending);
        end
        for (int j = 1; j <= 64; j++) begin
            cyc();
            if (j == 64) exp_clk = ~exp_clk;
            ev = {(j % 4 == 0), (j == 32), (j == 64), exp_clk};
            n_chk++;
            if ({os_tick, mid_tick, baud_tick, clock_out} !== ev) begin
                n_fail++; $display("FAIL div4 j=%0d got %b want %b", j, {os_tick, mid_tick, baud_tick, clock_out}, ev);
            end
        end
    endtask

`ifdef FRAC_DIV_EN
    task automatic test_frac();
        int next_t = 4;
        int cnt = 0;
        int obs = 0, obs_first = 0, obs_last = 0;
        logic [4:0] acc = '0;
        logic       ext = 1'b0;
        logic       eos;
        restart = 1'b1; div_load = 1'b1; div_value = 16'd4; div_frac = 4'd8;
        cyc();
        restart = 1'b0; div_load = 1'b0;
        for (int j = 1; j <= 90; j++) begin
            cyc();
            eos = (j == next_t);
            if (eos) begin
                cnt++;
                acc    = {1'b0, acc[3:0]} + 5'd8;
                ext    = acc[4];
                next_t = j + 4 + int'(ext);
            end
            if (os_tick === 1'b1) begin
                obs++;
                if (obs == 1)  obs_first = j;
                if (obs == 17) obs_last  = j;
            end
            n_chk++;
            if (os_tick !== eos) begin
                n_fail++; $display("FAIL frac j=%0d os_tick got %b want %b", j, os_tick, eos);
            end
        end
        n_chk++;
        if (obs_last - obs_first !== 72) begin
            n_fail++; $display("FAIL frac_span got %0d want 72", obs_last - obs_first);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_legacy();
        test_div_load();
        test_div_err();
        test_restart();
        test_enable();
        test_back_to_back();
`ifdef FRAC_DIV_EN
        test_frac();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised successor to the receiver's fixed divide-by-16 clock divider. It divides baurd_clk by a runtime-programmable divisor to produce a single-cycle oversample tick. It then divides that tick by OVERSAMPLE to give baud and mid-bit strobes, plus a legacy square-wave clock_out. It sits between the system clock and the UART RX/TX FSMs, and supports restart on a start-bit edge so sampling aligns to mid-bit.

Parameters:
DIV_WIDTH, 16, width of divisor and prescaler counter
OVERSAMPLE, 16, oversample ticks per bit; power of two, 4..64
DEFAULT_DIV, 1, divisor loaded at reset; must be nonzero and fit DIV_WIDTH

Ports:
baurd_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  counting enable; low freezes all counters
restart  in  1  one-cycle pulse; realign counters (start-bit detect)
div_load  in  1  one-cycle strobe; capture div_value into shadow register
div_value  in  DIV_WIDTH  new integer divisor, 0 illegal
os_tick  out  1  one-cycle pulse every div_active enabled cycles
mid_tick  out  1  one-cycle pulse at the OVERSAMPLE/2-th os_tick of each bit
baud_tick  out  1  one-cycle pulse at the OVERSAMPLE-th os_tick of each bit
clock_out  out  1  toggles on every baud_tick
div_active  out  DIV_WIDTH  divisor currently in use
div_pending  out  1  shadow holds a value not yet applied
div_err  out  1  sticky: div_load attempted with div_value==0

Behaviour:
- One clock (baurd_clk). Reset is synchronous, active-low: sampled on the rising edge of baurd_clk, with reset low forcing reset state.
- Reset state: pre_cnt=0, os_cnt=0, div_active=shadow=DEFAULT_DIV, and os_tick, mid_tick, baud_tick, clock_out, div_pending, div_err all 0.
- All outputs are registered. Ticks are high for exactly one cycle.
- Prescaler: when enable=1, pre_cnt counts 0..div_active-1 and wraps.
  - os_tick is asserted in the cycle after pre_cnt==div_active-1 is reached.
  - After reset release with enable held high, the first os_tick is high after the div_active-th edge. Period is exactly div_active cycles.
  - div_active=1 gives os_tick high on every enabled cycle.
- Oversample counter: os_cnt (log2 OVERSAMPLE bits) increments on each os_tick and wraps at OVERSAMPLE-1.
  - mid_tick is asserted together with the os_tick that moves os_cnt from OVERSAMPLE/2-1 to OVERSAMPLE/2.
  - baud_tick is asserted together with the os_tick that wraps os_cnt to 0.
- clock_out inverts on each baud_tick, giving period 2*div_active*OVERSAMPLE.
- enable=0: pre_cnt, os_cnt and clock_out hold, and all ticks are 0. Counting resumes from the held values.
- restart=1 (regardless of enable): pre_cnt, os_cnt and the fractional accumulator clear to 0; no tick is issued that cycle; clock_out holds. restart has priority over tick generation.
- Divisor update:
  - div_load with div_value!=0: shadow<=div_value and div_pending<=1. A later load before apply overwrites the shadow.
  - div_load with div_value==0: load ignored, div_err<=1. div_err clears only on reset.
  - Apply event = a cycle in which baud_tick is generated, or restart=1. On apply with div_pending=1: div_active<=shadow, div_pending<=0.
  - div_load coincident with an apply event: the new div_value is applied directly and div_pending stays 0.
- A divisor change never truncates or extends a bit period in progress, except on restart.

Optional Feature:
FRAC_DIV_EN. When defined:
- Adds parameter FRAC_W (default 4) and input div_frac [FRAC_W-1:0], captured by div_load alongside div_value and applied with it.
- An FRAC_W-bit accumulator adds the active fraction on each os_tick. On carry-out, the next prescaler period is div_active+1.
- Average os_tick period is div_active + div_frac/2^FRAC_W.
- div_value==0 is still an error regardless of div_frac.

When undefined: the div_frac port and the accumulator are absent, and the period is exactly div_active.

Decomposition:
- Package uart_baud_pkg holds the default constants for DIV_WIDTH, OVERSAMPLE, DEFAULT_DIV and FRAC_W, and the OS_CNT_W = log2(OVERSAMPLE) function/constant.
- One sub-module, uart_prescaler, contains pre_cnt, the fractional accumulator (under FRAC_DIV_EN) and os_tick generation.
- The top level holds os_cnt, the shadow/apply logic, clock_out and div_err.

Test Plan:
- Reset, DEFAULT_DIV=1, OVERSAMPLE=16, enable=1 -> os_tick every cycle, baud_tick every 16 cycles, clock_out period 32 cycles, matching the legacy divider.
- div_load div_value=5, then run 200 cycles -> div_pending=1 until the next baud_tick; afterwards os_tick every 5 cycles, mid_tick 40 cycles and baud_tick 80 cycles after that apply cycle.
- div_load div_value=0 -> div_active unchanged, div_err=1 and stays set across further valid loads until reset.
- Divisor 3, pulse restart mid-bit at os_cnt=9 -> no tick that cycle; first mid_tick 24 cycles later, baud_tick 48 cycles later.
- Toggle enable low for 7 cycles mid-period -> zero ticks while low; the tick sequence resumes shifted by exactly 7 cycles.
- FRAC_DIV_EN, div 4, div_frac=8 (FRAC_W=4) -> os_tick intervals alternate 4,5; 16 ticks span 72 cycles.
